// File: rtl/demux1_16_8b_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux1_16_8b_reg_if : byte-source / 16-consumer bundle for demux1_16_8b_reg |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface demux1_16_8b_reg_if;
  logic [7:0]   in;
  logic         in_valid;
  logic         in_ready;
  logic         sel3;
  logic         sel2;
  logic         sel1;
  logic         sel0;
  logic         auto;
  logic [127:0] out;
  logic [15:0]  out_valid;
  logic [15:0]  out_ack;
  logic [3:0]   rr_ptr;

  modport master (
    output in, in_valid, sel3, sel2, sel1, sel0, auto, out_ack,
    input  in_ready, out, out_valid, rr_ptr
  );

  modport slave (
    input  in, in_valid, sel3, sel2, sel1, sel0, auto, out_ack,
    output in_ready, out, out_valid, rr_ptr
  );
endinterface
`default_nettype wire

// File: rtl/demux1_16_8b_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | demux1_16_8b_reg : registered 1-to-16 byte distributor, manual/round-robin |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module demux1_16_8b_reg (
  input  wire logic          clk,
  input  wire logic          rst_n,
  demux1_16_8b_reg_if.slave  bus
);

  logic [7:0]   data_q [16];
  logic [7:0]   data_d [16];
  logic [15:0]  valid_q;
  logic [15:0]  valid_d;
  logic [3:0]   rr_ptr_q;
  logic [3:0]   rr_ptr_d;
  logic [3:0]   w_dest;
  logic         w_ready;
  logic         w_accept;
  logic [127:0] w_out;

  always_comb begin
    w_dest   = bus.auto ? rr_ptr_q : {bus.sel3, bus.sel2, bus.sel1, bus.sel0};
    // An ack on the destination frees the slot in the same cycle, so no bubble.
    w_ready  = ~valid_q[w_dest] | bus.out_ack[w_dest];
    w_accept = bus.in_valid & w_ready;
  end

  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q & ~bus.out_ack;
    rr_ptr_d = rr_ptr_q;
    if (w_accept) begin
      data_d[w_dest]  = bus.in;
      valid_d[w_dest] = 1'b1;
      if (bus.auto) begin
        rr_ptr_d = rr_ptr_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        data_q[i] <= 8'h00;
      end
      valid_q  <= 16'h0000;
      rr_ptr_q <= 4'd0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    w_out = '0;
    for (int i = 0; i < 16; i++) begin
      w_out[8*i +: 8] = data_q[i];
    end
  end

  assign bus.out       = w_out;
  assign bus.out_valid = valid_q;
  assign bus.in_ready  = w_ready;
  assign bus.rr_ptr    = rr_ptr_q;

endmodule
`default_nettype wire

// File: doc/demux1_16_8b_reg.md
# demux1_16_8b_reg

Registered 1-to-16 byte distributor: accepts one 8-bit byte per handshake and delivers it to one of sixteen output channels, each with its own one-entry holding register and valid/acknowledge handshake. It is the distribution counterpart of the 16:1 byte selector in the datapath. It fans a single byte source out to sixteen consumers, selected either by four explicit select bits or by an internal round-robin pointer.

## Interface
Parameters:
- none; data width fixed at 8 bits, channel count fixed at 16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in  input  8  byte to distribute.
- in_valid  input  1  source presents a byte on in.
- in_ready  output  1  block can accept the byte this cycle.
- sel3, sel2, sel1, sel0  input  1 each  manual destination index, {sel3,sel2,sel1,sel0}; used when auto=0.
- auto  input  1  1: destination is the internal round-robin pointer; 0: destination is the sel bits.
- out  output  128  channel data, flattened; channel i occupies out[8*i+7:8*i].
- out_valid  output  16  bit i set while channel i holds an unconsumed byte.
- out_ack  input  16  bit i: consumer i takes the byte this cycle.
- rr_ptr  output  4  current round-robin pointer (status).

## Operation
- Per channel i: data register d_i (8 b), flag v_i. out slice i = d_i, out_valid[i] = v_i.
- dest = auto ? rr_ptr : {sel3,sel2,sel1,sel0}. This is combinational from the current inputs and pointer.
- in_ready = ~v_dest | out_ack[dest]. This is combinational. There is a path from out_ack to in_ready.
- Accept = in_valid & in_ready. On accept: d_dest <= in, v_dest <= 1.
- On accept with auto=1: rr_ptr <= rr_ptr + 1, 4-bit modulo, so 15 wraps to 0. The pointer holds when auto=0 or when there is no accept.
- Consume: out_ack[i] & v_i clears v_i at the next edge. d_i keeps its last value after clearing.
- Simultaneous consume and accept on the same channel: v_i stays 1 and d_i takes the new byte. There is no bubble, and the old byte counts as consumed.
- Consumes on other channels proceed independently in the same cycle. All 16 channels may be acknowledged at once.
- out_ack[i] while v_i=0 has no effect.
- in_valid=0: no write, regardless of in_ready.
- Stall: if in_ready=0, the byte is not taken. The source must hold in, in_valid and destination stable until accept. Behaviour under a changing destination is defined by the combinational rule above.
- Toggling auto does not reset rr_ptr. The manual selection does not move the pointer.

## Timing
- Reset (rst_n=0, asynchronous): all v_i=0, all d_i=8'h00, rr_ptr=0. So out=0, out_valid=0, rr_ptr=0, and in_ready=1 while reset is held.
- Reset mid-operation discards all held bytes immediately. Nothing is accepted during reset. The first accept is possible at the first rising edge with rst_n=1.
- Latency: a byte accepted at edge N is visible on out/out_valid from edge N until consumed. That is one cycle from in to out.
- Throughput: one byte per cycle while the destination is empty or acknowledged in the same cycle.
- Full condition: all v_i=1 with no acks gives in_ready=0 for any destination.

## Test plan
- Reset: assert rst_n=0 mid-run with channels 3 and 9 valid -> out_valid=16'h0000, out=0, rr_ptr=0 immediately, before any clock edge.
- Manual route: auto=0, sel=4'b0101, in=8'hA5, in_valid for 1 cycle -> next cycle out_valid=16'h0020, out[47:40]=8'hA5, all other slices unchanged. Then out_ack[5]=1 for one cycle -> out_valid=0.
- Backpressure: channel 5 holds 8'hA5, no ack, send 8'h3C to sel=5 -> in_ready=0, the 8'hA5 byte is retained. Raise out_ack[5] -> in_ready=1 that same cycle, and the next cycle has out[47:40]=8'h3C with out_valid[5] still 1.
- Auto wrap: auto=1, 17 consecutive bytes 8'h00..8'h10, acking each channel the cycle after its byte is written -> channel k receives byte k for k=0..15. Byte 8'h10 lands in channel 0, and rr_ptr ends at 1.
- Full/mixed: fill all 16 channels manually, then hold in_valid -> in_ready=0. Ack channels 2 and 14 together -> both flags clear next cycle. Accepts to 2 or 14 succeed, and any other destination still stalls.
- Auto toggle: auto=1 with rr_ptr=7, then switch to auto=0 and send 3 bytes to sel=0 -> rr_ptr stays 7. Return to auto=1 -> next byte goes to channel 7.
